h2_seq_ctrl: RTL

Sequencer for the `h2_block` loop-filter stage of the delta-sigma chain. It accepts samples over a valid/ready handshake and issues them to `h2_block` at a fixed sample-rate tick. It drives the 16-bit `h2_block` reset bus through init and flush, suppresses outputs while the filter settles, and tags each valid filter output.

---
 rtl/h2_pkg.sv | 18 +
 rtl/h2_tick_gen.sv | 28 ++
 rtl/h2_seq_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/h2_pkg.sv
// Shared definitions for the h2_block sequencer: state encoding, default
// sample width and the h2_block reset-bus levels.
package h2_pkg;

  localparam int W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FLUSH  = 3'd4
  } h2_state_t;

  localparam logic [W_DEF-1:0] H2_RST_ON  = '1;
  localparam logic [W_DEF-1:0] H2_RST_OFF = '0;

endpackage

// File: rtl/h2_tick_gen.sv
// Sample-rate counter: counts 0..RATE_DIV-1 while enabled, sits at zero
// otherwise, and flags the last count of each period as the tick.
module h2_tick_gen #(
  parameter int RATE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(RATE_DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
    end else if (cnt == CW'(RATE_DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == CW'(RATE_DIV - 1));

endmodule

// File: rtl/h2_seq_ctrl.sv
// Sequencer for the h2_block loop filter: init/settle/run/flush control,
// one-entry sample holding register, rate-tick issue and output tagging.
module h2_seq_ctrl
  import h2_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int RATE_DIV = 4,
  parameter int H2_LAT   = 1,
  parameter int INIT_CYC = 2,
  parameter int SETTLE_N = 4,
  parameter int FLUSH_N  = 8
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         start,
  input  logic         flush,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  output logic         s_ready,
  output logic [W-1:0] h2_in,
  output logic [W-1:0] h2_reset,
  input  logic [W-1:0] h2_out,
  output logic         m_valid,
  output logic [W-1:0] m_data,
  output logic         underrun,
  output logic [2:0]   state
);

  localparam int ICW = $clog2(INIT_CYC + 1);
  localparam int SCW = $clog2(SETTLE_N + 1);
  localparam int FCW = $clog2(FLUSH_N + 1);

  h2_state_t    cur, nxt;
  logic [ICW-1:0] init_cnt;
  logic [SCW-1:0] out_cnt;
  logic [FCW-1:0] fl_cnt;
  logic           ent_full;
  logic [W-1:0]   ent_data;
  logic [W-1:0]   h2_in_q;
  logic [H2_LAT:0] dl;
  logic           und_q;

  logic tick, tick_en, issue, load, emerge, start_go, rst_active;

  h2_tick_gen #(.RATE_DIV(RATE_DIV)) u_tick (
    .clk   (CLK),
    .reset (reset),
    .en    (tick_en),
    .tick  (tick)
  );

  always_ff @(posedge CLK) begin
    if (reset) cur <= ST_IDLE;
    else       cur <= nxt;
  end

  // dl[0] lines up with the h2_in update; dl[H2_LAT] with the matching h2_out.
  always_comb begin
    nxt        = cur;
    rst_active = (cur == ST_IDLE) || (cur == ST_INIT);
    tick_en    = (cur == ST_SETTLE) || (cur == ST_RUN) || (cur == ST_FLUSH);
    s_ready    = ((cur == ST_SETTLE) || (cur == ST_RUN)) && !ent_full;
    load       = s_valid && s_ready;
    start_go   = (cur == ST_IDLE) && start;
    emerge     = dl[H2_LAT];
    issue      = tick && !((cur == ST_FLUSH) && (fl_cnt == FCW'(FLUSH_N)));
    case (cur)
      ST_IDLE:   if (start) nxt = ST_INIT;
      ST_INIT:   if (init_cnt == ICW'(INIT_CYC - 1)) nxt = ST_SETTLE;
      ST_SETTLE: begin
        if (flush) nxt = ST_FLUSH;
        else if (emerge && (out_cnt == SCW'(SETTLE_N - 1))) nxt = ST_RUN;
      end
      ST_RUN:    if (flush) nxt = ST_FLUSH;
      ST_FLUSH:  begin
        if ((fl_cnt == FCW'(FLUSH_N)) && emerge && (dl[H2_LAT-1:0] == '0))
          nxt = ST_IDLE;
      end
      default:   nxt = ST_IDLE;
    endcase
  end

  // A tick always consumes the entry as it stood before any same-cycle load.
  always_ff @(posedge CLK) begin
    if (reset || start_go) begin
      init_cnt <= '0;
      out_cnt  <= '0;
      fl_cnt   <= '0;
      ent_full <= 1'b0;
      ent_data <= '0;
      h2_in_q  <= '0;
      dl       <= '0;
      und_q    <= 1'b0;
    end else begin
      init_cnt <= (cur == ST_INIT) ? init_cnt + 1'b1 : '0;
      dl       <= {dl[H2_LAT-1:0], issue};
      if (emerge && (out_cnt != SCW'(SETTLE_N))) out_cnt <= out_cnt + 1'b1;
      if (issue) begin
        h2_in_q <= ent_full ? ent_data : '0;
        if ((cur == ST_RUN) && !ent_full) und_q <= 1'b1;
        if (cur == ST_FLUSH) fl_cnt <= fl_cnt + 1'b1;
      end
      if (load) begin
        ent_full <= 1'b1;
        ent_data <= s_data;
      end else if (issue) begin
        ent_full <= 1'b0;
      end
    end
  end

  assign h2_reset = rst_active ? {W{H2_RST_ON[0]}} : {W{H2_RST_OFF[0]}};
  assign h2_in    = rst_active ? '0 : h2_in_q;
  assign m_valid  = emerge && (out_cnt == SCW'(SETTLE_N));
  assign m_data   = emerge ? h2_out : '0;
  assign underrun = und_q;
  assign state    = cur;

endmodule
